// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: valid/ready handshake, optional two-entry skid buffer,
// synchronous bubble-inserting flush and saturating stall/flush event counters.
module pipe_stage_elastic #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SKID      = 1,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [1:0]           occupancy,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StFull  = 2'd1,
      StSkid  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     main_q, main_d;
   logic [WIDTH-1:0]     skid_q, skid_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic                 acc, deq;

   assign out_valid = (state_q != StEmpty);
   assign out_data  = (state_q == StEmpty) ? '0 : main_q;
   assign occupancy = state_q;
   // Skid mode derives in_ready from state only, so there is no path from out_ready.
   assign in_ready  = (SKID != 0) ? (state_q != StSkid) : (!out_valid || out_ready);
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   always_comb begin
      acc     = in_valid && in_ready && !flush;
      deq     = out_valid && out_ready;
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (flush) begin
         state_d = StEmpty;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         case (state_q)
            StEmpty: begin
               if (acc) begin
                  state_d = StFull;
                  main_d  = in_data;
               end
            end
            StFull: begin
               if (acc && deq) begin
                  main_d = in_data;
               end else if (acc && (SKID != 0)) begin
                  state_d = StSkid;
                  skid_d  = in_data;
               end else if (deq) begin
                  state_d = StEmpty;
                  main_d  = '0;
               end
            end
            StSkid: begin
               if (deq) begin
                  state_d = StFull;
                  main_d  = skid_q;
                  skid_d  = '0;
               end
            end
            default: begin
               state_d = StEmpty;
               main_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (out_valid && !out_ready && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
      // Only flushes that actually discard something are counted.
      if (flush && (state_q != StEmpty) && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StEmpty;
         main_q      <= '0;
         skid_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: three instances (skid, single-register, 2-bit counters) share
// stimulus and are checked every cycle against a capacity-limited FIFO model.
module tb_pipe_stage_elastic;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, flush, out_ready;
   logic [W-1:0] in_data;

   // Instance 0: SKID=1, 1: SKID=0, 2: SKID=1 with CNT_WIDTH=2.
   logic         ov0, ov1, ov2, rdy0, rdy1, rdy2;
   logic [W-1:0] od0, od1, od2;
   logic [1:0]   occ0, occ1, occ2;
   logic [15:0]  sc0, sc1, fc0, fc1;
   logic [1:0]   sc2, fc2;

   int n_vec = 0;
   int n_err = 0;

   int           m_cnt [3];
   logic [W-1:0] m_ent [3][2];
   int           m_sc  [3];
   int           m_fc  [3];
   int           cap   [3] = '{2, 1, 2};
   int           cmax  [3] = '{65535, 65535, 3};

   always #5 clk = ~clk;

   pipe_stage_elastic #(.WIDTH(W), .SKID(1), .CNT_WIDTH(16)) u_skid (
      .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .flush(flush), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
      .occupancy(occ0), .stall_cnt(sc0), .flush_cnt(fc0)
   );

   pipe_stage_elastic #(.WIDTH(W), .SKID(0), .CNT_WIDTH(16)) u_reg (
      .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .flush(flush), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
      .occupancy(occ1), .stall_cnt(sc1), .flush_cnt(fc1)
   );

   pipe_stage_elastic #(.WIDTH(W), .SKID(1), .CNT_WIDTH(2)) u_cnt (
      .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
      .flush(flush), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
      .occupancy(occ2), .stall_cnt(sc2), .flush_cnt(fc2)
   );

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", nm, i, $time, act, exp);
      end
   endtask

   function automatic bit m_rdy(input int i);
      if (cap[i] == 2) return m_cnt[i] < 2;
      return (m_cnt[i] == 0) || out_ready;
   endfunction

   task automatic cmp_inst(input int i, input logic ov, input logic rdy, input logic [W-1:0] od,
                           input logic [1:0] occ, input logic [15:0] sc, input logic [15:0] fc);
      logic [W-1:0] exp_d;
      exp_d = (m_cnt[i] > 0) ? m_ent[i][0] : '0;
      chk("out_valid", i, 32'(ov), 32'(m_cnt[i] > 0));
      chk("out_data", i, 32'(od), 32'(exp_d));
      chk("in_ready", i, 32'(rdy), 32'(m_rdy(i)));
      chk("occupancy", i, 32'(occ), 32'(m_cnt[i]));
      chk("stall_cnt", i, 32'(sc), 32'(m_sc[i]));
      chk("flush_cnt", i, 32'(fc), 32'(m_fc[i]));
   endtask

   // Reference model: a FIFO of capacity cap[i]; dequeue happens before enqueue in a cycle.
   initial begin : model
      bit ov, rdy;
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
               m_cnt[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end else begin
               ov  = m_cnt[i] > 0;
               rdy = m_rdy(i);
               if (ov && !out_ready && m_sc[i] < cmax[i]) m_sc[i]++;
               if (flush) begin
                  if (m_cnt[i] > 0 && m_fc[i] < cmax[i]) m_fc[i]++;
                  m_cnt[i] = 0;
               end else begin
                  if (ov && out_ready) begin
                     m_ent[i][0] = m_ent[i][1];
                     m_cnt[i]--;
                  end
                  if (in_valid && rdy) begin
                     m_ent[i][m_cnt[i]] = in_data;
                     m_cnt[i]++;
                  end
               end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         cmp_inst(0, ov0, rdy0, od0, occ0, sc0, fc0);
         cmp_inst(1, ov1, rdy1, od1, occ1, sc1, fc1);
         cmp_inst(2, ov2, rdy2, od2, occ2, {14'b0, sc2}, {14'b0, fc2});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      #2;
      chk("rst_out_valid", 0, 32'(ov0), 32'd0);
      chk("rst_in_ready", 0, 32'(rdy0), 32'd1);
      chk("rst_occupancy", 0, 32'(occ0), 32'd0);
      tick();
      rst_n = 1'b1;

      // Back-to-back stream.
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
      tick(); chk("stream_11", 0, 32'(od0), 32'h11); chk("stream_occ", 0, 32'(occ0), 32'd1);
      in_data = 8'h22;
      tick(); chk("stream_22", 0, 32'(od0), 32'h22);
      in_data = 8'h33;
      tick(); chk("stream_33", 0, 32'(od0), 32'h33); chk("stream_occ", 0, 32'(occ0), 32'd1);
      in_valid = 1'b0;
      tick(); chk("stream_empty", 0, 32'(ov0), 32'd0); chk("stream_stall", 0, 32'(sc0), 32'd0);

      // Skid absorption and in-order drain.
      in_valid = 1'b1; in_data = 8'hA0;
      tick(); in_data = 8'hA1;
      tick(); chk("skid_a1", 0, 32'(od0), 32'hA1);
      in_data = 8'hA2; out_ready = 1'b0;
      tick(); chk("skid_occ2", 0, 32'(occ0), 32'd2); chk("skid_rdy0", 0, 32'(rdy0), 32'd0);
      chk("skid_stall1", 0, 32'(sc0), 32'd1);
      in_data = 8'hA3;
      tick(); chk("skid_stall2", 0, 32'(sc0), 32'd2);
      tick(); chk("skid_stall3", 0, 32'(sc0), 32'd3); chk("skid_hold_a1", 0, 32'(od0), 32'hA1);
      out_ready = 1'b1;
      tick(); chk("skid_a2", 0, 32'(od0), 32'hA2); chk("skid_rdy1", 0, 32'(rdy0), 32'd1);
      tick(); chk("skid_a3", 0, 32'(od0), 32'hA3);
      in_valid = 1'b0;
      tick(); chk("skid_drained", 0, 32'(occ0), 32'd0);

      // Flush with two entries and a payload on the input.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
      tick(); in_data = 8'h02;
      tick(); chk("fl_occ2", 0, 32'(occ0), 32'd2);
      flush = 1'b1; in_data = 8'h55;
      tick(); chk("fl_valid", 0, 32'(ov0), 32'd0); chk("fl_data", 0, 32'(od0), 32'd0);
      chk("fl_occ", 0, 32'(occ0), 32'd0); chk("fl_cnt1", 0, 32'(fc0), 32'd1);
      in_valid = 1'b0;
      tick(); chk("fl_empty_cnt", 0, 32'(fc0), 32'd1);
      flush = 1'b0;

      // Asynchronous reset mid-cycle with two entries held.
      in_valid = 1'b1; in_data = 8'h0C;
      tick(); in_data = 8'h0D;
      tick(); chk("ar_occ2", 0, 32'(occ0), 32'd2);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("ar_valid", 0, 32'(ov0), 32'd0); chk("ar_data", 0, 32'(od0), 32'd0);
      chk("ar_occ", 0, 32'(occ0), 32'd0); chk("ar_rdy", 0, 32'(rdy0), 32'd1);
      chk("ar_stall", 0, 32'(sc0), 32'd0); chk("ar_flush", 0, 32'(fc0), 32'd0);
      tick(); rst_n = 1'b1;
      tick();

      // Saturating 2-bit stall counter.
      in_valid = 1'b1; in_data = 8'h77;
      tick(); in_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("sat_cnt2", 2, 32'(sc2), 32'd3); chk("sat_cnt16", 0, 32'(sc0), 32'd6);

      // Single-register mode: combinational in_ready.
      chk("reg_rdy_low", 1, 32'(rdy1), 32'd0);
      in_valid = 1'b1; in_data = 8'h88; out_ready = 1'b1;
      #1 chk("reg_rdy_comb", 1, 32'(rdy1), 32'd1);
      tick(); chk("reg_occ1", 1, 32'(occ1), 32'd1); chk("reg_data", 1, 32'(od1), 32'h88);
      in_valid = 1'b0;
      tick();

      // Randomized traffic with rare flushes and asynchronous resets.
      for (int k = 0; k < 3000; k++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 19) == 0);
         in_data   = W'($urandom);
         tick();
      end
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
